// File: rtl/seg_pkg.sv
// Shared types and constants for the serial 7-segment display driver.
package seg_pkg;

  // Transfer sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } seg_state_e;

  // Width of one snapshot: four digits of eight segment bits each
  localparam int FRAME_W = 32;

  // Byte sent for a disabled digit: every segment and the point dark
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low segment patterns, bit order {dp,g,f,e,d,c,b,a}, dp dark
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg_p2s_driver_hex2seg7.sv
// One hex digit to an active-low segment byte with decimal point and blanking.
module hex2seg7
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       en_i,
  output logic [7:0] seg_o
);

  logic [7:0] pattern;

  // Look up the glyph, light the point on request, and blank disabled digits
  always_comb begin
    pattern = HEX_SEG[nibble_i];
    seg_o   = SEG_BLANK;
    if (en_i) begin
      seg_o = {pattern[7] & ~dp_i, pattern[6:0]};
    end
  end

endmodule

// File: rtl/seg_p2s_driver.sv
// Snapshots four decoded digits and shifts them MSB-first to an external
// shift-register display chain, then pulses the latch line.
module seg_p2s_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] num,
  input  logic [3:0]  point,
  input  logic [3:0]  le,
  input  logic        start,
  output logic        seg_clk,
  output logic        seg_dout,
  output logic        seg_latch,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  logic [FRAME_W-1:0] frame_d;
  logic [FRAME_W-1:0] frame_q;
  seg_state_e         state_q;
  logic [7:0]         div_cnt_q;
  logic [4:0]         bit_cnt_q;
  logic               seg_clk_q;
  logic               seg_latch_q;
  logic               busy_q;
  logic               done_q;

  // Four decoders build the frame that is captured on an accepted start
  for (genvar i = 0; i < 4; i++) begin : g_digit
    hex2seg7 u_hex2seg7 (
      .nibble_i (num[4*i +: 4]),
      .dp_i     (point[i]),
      .en_i     (le[i]),
      .seg_o    (frame_d[8*i +: 8])
    );
  end

  // Transfer sequencer: divide the clock, shift on falling seg_clk, then latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      seg_clk_q   <= 1'b0;
      seg_latch_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            frame_q   <= frame_d;
            seg_clk_q <= 1'b0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            if (!seg_clk_q) begin
              seg_clk_q <= 1'b1;
            end else begin
              seg_clk_q <= 1'b0;
              if (bit_cnt_q == 5'd31) begin
                seg_latch_q <= 1'b1;
                state_q     <= LATCH;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
                frame_q   <= frame_q << 1;
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        LATCH: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q   <= '0;
            seg_latch_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The data line is the head of the frame; it only moves on falling seg_clk
  assign seg_dout  = frame_q[FRAME_W-1];
  assign seg_clk   = seg_clk_q;
  assign seg_latch = seg_latch_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seg_p2s_driver.sv
// Directed bench for seg_p2s_driver: one instance at DIV=2, one at DIV=1.
module tb_seg_p2s_driver;

  logic        clk;
  logic        rst;
  logic [15:0] num;
  logic [3:0]  point;
  logic [3:0]  le;
  logic [1:0]  startS;
  logic [1:0]  segClk;
  logic [1:0]  segDout;
  logic [1:0]  segLatch;
  logic [1:0]  busyS;
  logic [1:0]  doneS;

  int          vectorCount = 0;
  int          miscompares = 0;

  logic [31:0] rxFrame0;
  logic [31:0] rxFrame1;
  int          rxCount0 = 0;
  int          rxCount1 = 0;

  // Instance 0 runs the default divider
  seg_p2s_driver #(.DIV(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .num       (num),
    .point     (point),
    .le        (le),
    .start     (startS[0]),
    .seg_clk   (segClk[0]),
    .seg_dout  (segDout[0]),
    .seg_latch (segLatch[0]),
    .busy      (busyS[0]),
    .done      (doneS[0])
  );

  // Instance 1 toggles seg_clk every system clock
  seg_p2s_driver #(.DIV(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .num       (num),
    .point     (point),
    .le        (le),
    .start     (startS[1]),
    .seg_clk   (segClk[1]),
    .seg_dout  (segDout[1]),
    .seg_latch (segLatch[1]),
    .busy      (busyS[1]),
    .done      (doneS[1])
  );

  // Free-running system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver model for chain 0: sample data on each rising seg_clk
  always @(posedge segClk[0]) begin
    rxFrame0 <= {rxFrame0[30:0], segDout[0]};
    rxCount0 <= rxCount0 + 1;
  end

  // Receiver model for chain 1
  always @(posedge segClk[1]) begin
    rxFrame1 <= {rxFrame1[30:0], segDout[1]};
    rxCount1 <= rxCount1 + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Run one transfer on instance idx and check frame, pulses, latch and latency
  task automatic applyStimulus(input int idx, input bit doStart,
                               input logic [31:0] expFrame, input int expLat,
                               input int div, input string tag,
                               input bit midChange, input bit busyStarts);
    int baseRx;
    int latchCnt;
    int lat;
    baseRx   = (idx == 0) ? rxCount0 : rxCount1;
    latchCnt = 0;
    lat      = -1;
    if (doStart) begin
      @(negedge clk);
      startS[idx] = 1'b1;
    end
    @(posedge clk);
    #1;
    startS[idx] = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk);
      #1;
      startS[idx] = 1'b0;
      if (segLatch[idx]) latchCnt++;
      if (midChange && cyc == 20) num = ~num;
      if (busyStarts && (cyc == 30 || cyc == 100)) startS[idx] = 1'b1;
      if (doneS[idx]) begin
        lat = cyc;
        break;
      end
    end
    checkOutput({tag, "/frame"}, (idx == 0) ? rxFrame0 : rxFrame1, expFrame);
    checkOutput({tag, "/bits"},
                32'(((idx == 0) ? rxCount0 : rxCount1) - baseRx), 32'd32);
    checkOutput({tag, "/latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "/latch"}, 32'(latchCnt), 32'(div));
    checkOutput({tag, "/busyAtDone"}, {31'd0, busyS[idx]}, 32'd0);
  endtask

  initial begin
    int base;
    int stray;
    rst    = 1'b1;
    num    = 16'h0000;
    point  = 4'h0;
    le     = 4'hF;
    startS = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset/div2", {27'd0, segClk[0], segDout[0], segLatch[0], busyS[0], doneS[0]}, 32'd0);
    checkOutput("reset/div1", {27'd0, segClk[1], segDout[1], segLatch[1], busyS[1], doneS[1]}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    num = 16'h0010; point = 4'h0; le = 4'hF;
    applyStimulus(0, 1'b1, 32'hC0C0F9C0, 130, 2, "powerup", 1'b0, 1'b0);

    num = 16'h1234; point = 4'h0; le = 4'hF;
    applyStimulus(0, 1'b1, 32'hF9A4B099, 130, 2, "hex1234", 1'b0, 1'b0);

    num = 16'h89AF; point = 4'b0001; le = 4'hF;
    applyStimulus(0, 1'b1, 32'h8090880E, 130, 2, "hex89AF", 1'b0, 1'b0);

    num = 16'h0000; point = 4'hF; le = 4'hF;
    applyStimulus(0, 1'b1, 32'h40404040, 130, 2, "allPoints", 1'b0, 1'b0);

    num = 16'h1234; point = 4'hF; le = 4'b0000;
    applyStimulus(0, 1'b1, 32'hFFFFFFFF, 130, 2, "blankAll", 1'b0, 1'b0);

    num = 16'h5555; point = 4'h0; le = 4'b1010;
    applyStimulus(0, 1'b1, 32'h92FF92FF, 130, 2, "blankAlt", 1'b0, 1'b0);

    num = 16'h0010; point = 4'h0; le = 4'hF;
    applyStimulus(0, 1'b1, 32'hC0C0F9C0, 130, 2, "snapshot", 1'b1, 1'b0);

    num = 16'h1234; point = 4'h0; le = 4'hF;
    applyStimulus(0, 1'b1, 32'hF9A4B099, 130, 2, "busyStart", 1'b0, 1'b1);

    // Start raised in the done cycle is taken at the following edge
    num = 16'h5555; le = 4'b1010;
    startS[0] = 1'b1;
    applyStimulus(0, 1'b0, 32'h92FF92FF, 130, 2, "backToBack", 1'b0, 1'b0);

    // Abort a transfer after bit 10 has been clocked out
    num = 16'h89AF; point = 4'h0; le = 4'hF;
    @(negedge clk);
    startS[0] = 1'b1;
    @(posedge clk);
    #1;
    startS[0] = 1'b0;
    base = rxCount0;
    for (int c = 0; c < 400 && (rxCount0 - base) < 11; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rstMid/reach", 32'(rxCount0 - base), 32'd11);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstMid/outs", {27'd0, segClk[0], segDout[0], segLatch[0], busyS[0], doneS[0]}, 32'd0);
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (segLatch[0] || busyS[0] || doneS[0] || segClk[0]) stray++;
    end
    checkOutput("rstMid/quiet", 32'(stray), 32'd0);
    num = 16'h1234; point = 4'h0; le = 4'hF;
    applyStimulus(0, 1'b1, 32'hF9A4B099, 130, 2, "afterRst", 1'b0, 1'b0);

    num = 16'hFFFF; point = 4'h0; le = 4'hF;
    applyStimulus(1, 1'b1, 32'h8E8E8E8E, 65, 1, "div1", 1'b0, 1'b0);

    num = 16'h1234; point = 4'b1000; le = 4'hF;
    applyStimulus(1, 1'b1, 32'h79A4B099, 65, 1, "div1pt", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
    $finish;
  end

endmodule
